// File: rtl/bidir_pkg.sv
// Shared definitions for the bidirectional port controller: FSM state
// encoding and default width/synchroniser/turnaround settings.
package bidir_pkg;

  typedef enum logic [1:0] {
    LISTEN = 2'd0,
    TURN   = 2'd1,
    DRIVE  = 2'd2
  } state_t;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TURN_CYCLES = 2;

endpackage

// File: rtl/bidir_port_ctrl_if.sv
// Handshake/status bundle between a datapath client (master) and the
// bidirectional port controller (slave). The pad bus itself stays a plain inout.
interface bidir_port_ctrl_if #(parameter int WIDTH = 8);
  logic             dir_req;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             rx_en;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             driving;
  logic             contention_err;

  modport master (
    output dir_req, tx_data, tx_valid, rx_en,
    input  tx_ready, rx_data, rx_valid, driving, contention_err
  );

  modport slave (
    input  dir_req, tx_data, tx_valid, rx_en,
    output tx_ready, rx_data, rx_valid, driving, contention_err
  );
endinterface

// File: rtl/bidir_sync.sv
// WIDTH-bit, STAGES-deep flop synchroniser for the incoming pad bus,
// cleared by the asynchronous active-low reset.
module bidir_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] ff_p [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) ff_p[i] <= '0;
    end else begin
      ff_p[0] <= d;
      for (int i = 1; i < STAGES; i++) ff_p[i] <= ff_p[i-1];
    end
  end

  assign q = ff_p[STAGES-1];

endmodule

// File: rtl/bidir_port_ctrl.sv
// Bidirectional pad-bus controller with a LISTEN/TURN/DRIVE turnaround FSM,
// valid/ready TX, strobed RX. Optional drive check: BIDIR_CONTENTION_CHK_EN.
module bidir_port_ctrl
  import bidir_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TURN_CYCLES = DEF_TURN_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  bidir_port_ctrl_if.slave  bus,
  inout  wire [WIDTH-1:0]   bidir
);

  localparam int CNT_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES - 1);

  state_t           state_q, state_d;
  state_t           target_q, target_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             tx_ready;
  logic             tx_take;
  logic             rx_take;
  logic             driving_p1;
  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] rx_data_p1;
  logic             rx_vld_p1;

  // Input synchroniser: bus sampled here is SYNC_STAGES cycles old at sync_q
  bidir_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bidir),
    .q     (sync_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LISTEN;
      target_q <= LISTEN;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

  // A turnaround always runs to completion; dir_req is only re-read on arrival
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    case (state_q)
      LISTEN: begin
        if (bus.dir_req) begin
          state_d  = TURN;
          target_d = DRIVE;
          cnt_d    = TURN_LOAD;
        end
      end
      DRIVE: begin
        if (!bus.dir_req) begin
          state_d  = TURN;
          target_d = LISTEN;
          cnt_d    = TURN_LOAD;
        end
      end
      TURN: begin
        if (cnt_q == '0) state_d = target_q;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: begin
        state_d  = LISTEN;
        target_d = LISTEN;
        cnt_d    = '0;
      end
    endcase
  end

  always_comb begin
    tx_ready = (state_q == DRIVE);
    tx_take  = bus.tx_valid && tx_ready;
    rx_take  = bus.rx_en && (state_q == LISTEN);
  end

  // Stage p1: output enable, TX word and RX capture registered on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      driving_p1 <= 1'b0;
      out_reg    <= '0;
      rx_data_p1 <= '0;
      rx_vld_p1  <= 1'b0;
    end else begin
      driving_p1 <= (state_d == DRIVE);
      rx_vld_p1  <= rx_take;
      if (tx_take) out_reg    <= bus.tx_data;
      if (rx_take) rx_data_p1 <= sync_q;
    end
  end

  assign bidir        = driving_p1 ? out_reg : {WIDTH{1'bz}};
  assign bus.tx_ready = tx_ready;
  assign bus.driving  = driving_p1;
  assign bus.rx_data  = rx_data_p1;
  assign bus.rx_valid = rx_vld_p1;

`ifdef BIDIR_CONTENTION_CHK_EN
  localparam int QUIET = SYNC_STAGES + 1;
  localparam int QW    = $clog2(QUIET + 1);

  logic [QW-1:0] quiet_q;
  logic          err_q;

  // The compare waits until the synchroniser has seen the word being driven
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quiet_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (tx_take || (state_d == DRIVE && state_q != DRIVE))
        quiet_q <= '0;
      else if (state_q == DRIVE && quiet_q != QW'(QUIET))
        quiet_q <= quiet_q + QW'(1);
      if (state_q == DRIVE && quiet_q == QW'(QUIET) && sync_q != out_reg)
        err_q <= 1'b1;
    end
  end

  assign bus.contention_err = err_q;
`else
  assign bus.contention_err = 1'b0;
`endif

endmodule

// File: doc/bidir_port_ctrl.md
Name: bidir_port_ctrl

Overview:
Parametrised successor to the single-byte bidirectional port. Owns a WIDTH-bit tristate bus and controls direction through a turnaround state machine, so the port is never driven during a direction change. Adds a valid/ready transmit path, a synchronised and strobed receive path, and an optional drive-contention check. Sits between UART/peripheral datapaths and a shared bidirectional pad bus.

Parameters:
WIDTH, 8, bus and data width in bits (>=1)
SYNC_STAGES, 2, flops in the input synchroniser on the bus (>=1)
TURN_CYCLES, 2, idle cycles of bus turnaround between LISTEN and DRIVE (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
dir_req  input  1  1 = request drive, 0 = request listen
tx_data  input  WIDTH  word to drive
tx_valid  input  1  tx_data valid
tx_ready  output  1  accepts a word this cycle; high only in DRIVE
rx_en  input  1  sample strobe
rx_data  output  WIDTH  captured bus value
rx_valid  output  1  one-cycle pulse, rx_data updated
driving  output  1  registered output enable; bus is driven when 1
contention_err  output  1  sticky drive-mismatch flag (optional feature)
bidir  inout  WIDTH  bus; driven with out_reg when driving=1, else high-Z

Behaviour:
- Reset, asynchronous: state=LISTEN, driving=0 so bidir is high-Z immediately, out_reg=0, rx_data=0, rx_valid=0, tx_ready=0, turn counter=0, contention_err=0, synchroniser flops=0.
- States: LISTEN, TURN, DRIVE.
- LISTEN: driving=0. If dir_req=1, latch target=DRIVE, load counter=TURN_CYCLES-1, go to TURN.
- DRIVE: driving=1, tx_ready=1. If dir_req=0, latch target=LISTEN, load counter, go to TURN. tx_ready drops in the same cycle the state leaves DRIVE. A handshake on that edge is still accepted.
- TURN: driving=0, tx_ready=0, rx_en ignored. Counter decrements each cycle. At 0, enter the latched target. dir_req changes during TURN do not abort it; they are evaluated after arrival and can trigger a new TURN. TURN lasts exactly TURN_CYCLES cycles.
- driving is a registered decode of the next state, so it changes on the same edge as the state.
- TX: tx_valid&&tx_ready at edge N loads out_reg, and bidir carries the word from N+1. out_reg holds its value across turns and is re-driven on re-entering DRIVE. A tx_valid held while not in DRIVE waits; no word is lost.
- RX: in LISTEN, rx_en at edge N loads rx_data with the synchroniser output, i.e. the bus value SYNC_STAGES cycles earlier. rx_valid=1 for cycle N+1 only. rx_en outside LISTEN produces no pulse, and rx_data is held.
- Back-to-back rx_en gives a pulse every cycle. Back-to-back tx handshakes give a new word every cycle.
- Reset asserted mid-DRIVE: bus releases asynchronously and all state clears. No partial turn is carried over.

Optional Feature:
BIDIR_CONTENTION_CHK_EN
- Defined: in DRIVE, once SYNC_STAGES+1 cycles have elapsed since entry or since the last out_reg load, the synchronised bus is compared to out_reg every cycle. Any mismatch sets contention_err. It is sticky until rst_n.
- Undefined: contention_err is tied to 0 and no compare logic is built.

Decomposition:
- Shared package bidir_pkg holds the state enum/localparams (LISTEN=2'd0, TURN=2'd1, DRIVE=2'd2) and the default width and turnaround constants.
- One sub-module, bidir_sync: a WIDTH-bit SYNC_STAGES-deep synchroniser with asynchronous active-low reset, used for the input path.

Test Plan:
1. Reset, dir_req=0, bidir forced 8'h05, rx_en pulsed -> rx_valid 1 cycle, rx_data=8'h05 (SYNC_STAGES latency honoured), driving=0.
2. dir_req 0->1 at cycle 10 -> driving=0 for exactly TURN_CYCLES=2 cycles, then 1. tx_data=8'h0A accepted on the first DRIVE cycle, and bidir=8'h0A on the next cycle.
3. Three back-to-back tx words 8'h11/22/33 in DRIVE -> bidir shows each on consecutive cycles. Dropping dir_req -> high-Z for 2 cycles, then LISTEN.
4. dir_req toggled 1->0 mid-TURN -> the TURN completes into DRIVE, then a second 2-cycle TURN back to LISTEN. rx_en during TURN gives no rx_valid.
5. rst_n low asynchronously mid-DRIVE -> bidir high-Z immediately, all outputs at reset values, out_reg=0 on the next DRIVE.
6. With BIDIR_CONTENTION_CHK_EN, a testbench driver forces bidir=8'hFF while the block drives 8'h0A -> contention_err=1 and stays 1 until reset. Without the macro it stays 0.
